// File: rtl/axis_pipe_shift_arbiter_if.sv
// Bundle between NUM AXI-stream requesters, the packet arbiter and the shared shift pipe.
// The master view is the arbiter; the slave view is the requesters plus the pipe.
interface axis_pipe_shift_arbiter_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32
);
  localparam int IDW = $clog2(NUM);

  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic [IDW-1:0]       m_tid;
  logic                 m_tready;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/axis_pipe_shift_arbiter.sv
// Packet-locked round-robin arbiter feeding one shared shift pipe through a registered
// output stage that keeps 1 beat/cycle while the pipe is ready.
//
// state | meaning
// IDLE  | no packet owned; pick next valid requester after last_grant
// LOCK  | grant owns the pipe until its tlast beat has left or is leaving
module axis_pipe_shift_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axis_pipe_shift_arbiter_if.master    bus,
  output logic                         busy
);
  localparam int IDW = $clog2(NUM);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   grant_q;
  logic [IDW-1:0]   last_grant_q;
  logic             done_q;
  logic [DSIZE-1:0] m_tdata_q;
  logic             m_tvalid_q;
  logic             m_tlast_q;
  logic [IDW-1:0]   m_tid_q;

  logic             out_free;
  logic             gnt_ready;
  logic             gnt_valid;
  logic             gnt_last;
  logic [DSIZE-1:0] gnt_data;
  logic             accept;
  logic             leave;
  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  logic [IDW-1:0]   cand;
  logic [NUM-1:0]   s_tready_d;

  assign out_free  = !m_tvalid_q || bus.m_tready;
  assign gnt_ready = (state_q == LOCK) && !done_q && out_free;
  assign accept    = gnt_ready && gnt_valid;
  // Release the lock once the tlast beat is leaving the register, or as it is loaded
  // while the pipe is flowing, so back-to-back packets see a single idle input cycle.
  assign leave     = (accept && gnt_last && bus.m_tready) || (done_q && out_free);

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_last   = 1'b0;
    gnt_data   = '0;
    s_tready_d = '0;
    for (int i = 0; i < NUM; i++) begin
      if (grant_q == IDW'(i)) begin
        gnt_valid     = bus.s_tvalid[i];
        gnt_last      = bus.s_tlast[i];
        gnt_data      = bus.s_tdata[i*DSIZE +: DSIZE];
        s_tready_d[i] = gnt_ready;
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NUM);
      if (!sel_found && bus.s_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM - 1);
      done_q       <= 1'b0;
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tid_q      <= '0;
    end else begin
      if (accept) begin
        m_tdata_q  <= gnt_data;
        m_tlast_q  <= gnt_last;
        m_tid_q    <= grant_q;
        m_tvalid_q <= 1'b1;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q <= sel_idx;
            done_q  <= 1'b0;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (accept && gnt_last) begin
            done_q       <= 1'b1;
            last_grant_q <= grant_q;
          end
          if (leave) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.s_tready = s_tready_d;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tid    = m_tid_q;
  assign busy         = (state_q == LOCK);
endmodule

// File: tb/tb_axis_pipe_shift_arbiter.sv
// Directed bench for the packet arbiter: every expected beat, ready pattern and busy
// level below is worked out by hand from the cycle timing of the arbiter.
module tb_axis_pipe_shift_arbiter;
  localparam int NUM   = 4;
  localparam int DSIZE = 32;

  logic aclk = 1'b0;
  logic aresetn;
  logic busy;
  logic [NUM-1:0][DSIZE-1:0] tdat;
  logic [NUM-1:0]            tval;
  logic [NUM-1:0]            tlst;
  logic                      mrdy;
  int n_tot = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  axis_pipe_shift_arbiter_if #(.NUM(NUM), .DSIZE(DSIZE)) bus ();

  assign bus.s_tdata  = tdat;
  assign bus.s_tvalid = tval;
  assign bus.s_tlast  = tlst;
  assign bus.m_tready = mrdy;

  axis_pipe_shift_arbiter #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check s_tready for the inputs just driven, then the registered outputs.
  task automatic cyc(input string tag, input logic [3:0] e_rdy, input logic e_mv,
                     input logic [31:0] e_md, input logic e_ml, input logic [1:0] e_id,
                     input logic e_busy);
    #1;
    chk({tag, " s_tready"}, 64'(bus.s_tready), 64'(e_rdy));
    @(posedge aclk);
    #1;
    chk({tag, " m_tvalid"}, 64'(bus.m_tvalid), 64'(e_mv));
    if (e_mv) begin
      chk({tag, " m_tdata"}, 64'(bus.m_tdata), 64'(e_md));
      chk({tag, " m_tlast"}, 64'(bus.m_tlast), 64'(e_ml));
      chk({tag, " m_tid"}, 64'(bus.m_tid), 64'(e_id));
    end
    chk({tag, " busy"}, 64'(busy), 64'(e_busy));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tval    = '0;
    tlst    = '0;
    tdat    = '0;
    mrdy    = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int src;
    logic [31:0] base;
    logic [3:0] oh;

    // reset state
    do_reset();
    chk("rst m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst m_tdata", 64'(bus.m_tdata), 64'd0);
    chk("rst m_tlast", 64'(bus.m_tlast), 64'd0);
    chk("rst m_tid", 64'(bus.m_tid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst s_tready", 64'(bus.s_tready), 64'd0);

    // single requester 2, three beats
    tval[2] = 1'b1; tdat[2] = 32'hA0;
    cyc("one arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("one a0", 4'b0100, 1'b1, 32'hA0, 1'b0, 2'd2, 1'b1);
    tdat[2] = 32'hA1;
    cyc("one a1", 4'b0100, 1'b1, 32'hA1, 1'b0, 2'd2, 1'b1);
    tdat[2] = 32'hA2; tlst[2] = 1'b1;
    cyc("one a2", 4'b0100, 1'b1, 32'hA2, 1'b1, 2'd2, 1'b0);
    tval = '0; tlst = '0;
    cyc("one drain", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

    // all four requesters, 2-beat packets, order 0,1,2,3,0
    do_reset();
    tval = 4'b1111;
    for (int i = 0; i < NUM; i++) tdat[i] = 32'hB0 + 32'(2 * i);
    for (int p = 0; p < 5; p++) begin
      src  = p % 4;
      base = (p == 4) ? 32'hC0 : 32'hB0 + 32'(2 * p);
      oh   = 4'b0001 << src;
      cyc("rr arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      cyc("rr beat0", oh, 1'b1, base, 1'b0, src[1:0], 1'b1);
      if (p < 4) begin
        tdat[src] = base + 32'd1; tlst[src] = 1'b1;
        cyc("rr beat1", oh, 1'b1, base + 32'd1, 1'b1, src[1:0], 1'b0);
        tdat[src] = (src == 0) ? 32'hC0 : 32'hEE; tlst[src] = 1'b0;
      end
    end

    // backpressure 1,0,0,1 on a 4-beat packet from requester 1
    do_reset();
    tval = 4'b0010; tdat[1] = 32'hD0;
    cyc("bp arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("bp d0", 4'b0010, 1'b1, 32'hD0, 1'b0, 2'd1, 1'b1);
    tdat[1] = 32'hD1; mrdy = 1'b0;
    cyc("bp stall1", 4'b0000, 1'b1, 32'hD0, 1'b0, 2'd1, 1'b1);
    cyc("bp stall2", 4'b0000, 1'b1, 32'hD0, 1'b0, 2'd1, 1'b1);
    mrdy = 1'b1;
    cyc("bp d1", 4'b0010, 1'b1, 32'hD1, 1'b0, 2'd1, 1'b1);
    tdat[1] = 32'hD2;
    cyc("bp d2", 4'b0010, 1'b1, 32'hD2, 1'b0, 2'd1, 1'b1);
    tdat[1] = 32'hD3; tlst[1] = 1'b1;
    cyc("bp d3", 4'b0010, 1'b1, 32'hD3, 1'b1, 2'd1, 1'b0);
    tval = '0; tlst = '0;
    cyc("bp drain", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);

    // single-beat packets from requesters 0 and 3
    do_reset();
    tval = 4'b1001; tlst = 4'b1001; tdat[0] = 32'hE0; tdat[3] = 32'hE3;
    for (int k = 0; k < 4; k++) begin
      src  = (k % 2 == 1) ? 3 : 0;
      oh   = 4'b0001 << src;
      base = (src == 0) ? 32'hE0 : 32'hE3;
      cyc("sb arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
      cyc("sb beat", oh, 1'b1, base, 1'b1, src[1:0], 1'b0);
    end

    // reset after beat 2 of 5 from requester 1
    do_reset();
    tval = 4'b0010; tdat[1] = 32'hF0;
    cyc("mr arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("mr f0", 4'b0010, 1'b1, 32'hF0, 1'b0, 2'd1, 1'b1);
    tdat[1] = 32'hF1;
    cyc("mr f1", 4'b0010, 1'b1, 32'hF1, 1'b0, 2'd1, 1'b1);
    tdat[1] = 32'hF2;
    aresetn = 1'b0;
    tval = 4'b0011; tdat[0] = 32'h60; tlst[0] = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    chk("mr m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("mr busy", 64'(busy), 64'd0);
    chk("mr s_tready", 64'(bus.s_tready), 64'd0);
    cyc("mr arb2", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("mr first", 4'b0001, 1'b1, 32'h60, 1'b1, 2'd0, 1'b0);

    // stall on the tlast beat
    do_reset();
    mrdy = 1'b0;
    tval = 4'b0100; tlst = 4'b0100; tdat[2] = 32'h70;
    cyc("tl arb", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("tl load", 4'b0100, 1'b1, 32'h70, 1'b1, 2'd2, 1'b1);
    tdat[2] = 32'h71; tval = 4'b0101; tlst = 4'b0101; tdat[0] = 32'h80;
    cyc("tl hold1", 4'b0000, 1'b1, 32'h70, 1'b1, 2'd2, 1'b1);
    cyc("tl hold2", 4'b0000, 1'b1, 32'h70, 1'b1, 2'd2, 1'b1);
    mrdy = 1'b1;
    cyc("tl release", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    cyc("tl arb2", 4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
    cyc("tl next", 4'b0001, 1'b1, 32'h80, 1'b1, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
